// File: rtl/ps2_key_event_decoder_if.sv
// Byte stream from the PS/2 scancode driver and the decoded key events
// that go on to the game FSM.
interface ps2_key_event_decoder_if;
   logic       scan_ready;
   logic [7:0] scan_code;
   logic       key_valid;
   logic       key_make;
   logic [3:0] key_index;
   logic [8:0] key_held;
   logic       start_pulse;
   logic       sync_lost;

   // Keyboard-driver side: presents bytes, observes events.
   modport master (
      output scan_ready, scan_code,
      input  key_valid, key_make, key_index, key_held, start_pulse, sync_lost
   );

   // Decoder side: consumes bytes, produces events.
   modport slave (
      input  scan_ready, scan_code,
      output key_valid, key_make, key_index, key_held, start_pulse, sync_lost
   );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 byte stream to per-key press/release events for the nine
// whac-a-mole holes (Q W E / A S D / Z X C) plus a Space start pulse.
// Handles F0/E0 prefixes, typematic repeat suppression and prefix timeout.
module ps2_key_event_decoder #(
   parameter int TIMEOUT_CYCLES  = 250000,
   parameter bit SUPPRESS_REPEAT = 1'b1
) (
   input logic                     CLOCK_50,
   input logic                     reset,
   ps2_key_event_decoder_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   // Returns {is_hole, hole_index} for a Set-2 make code.
   function automatic logic [4:0] hole_map(input logic [7:0] code);
      case (code)
         8'h15:   return {1'b1, 4'd0};
         8'h1D:   return {1'b1, 4'd1};
         8'h24:   return {1'b1, 4'd2};
         8'h1C:   return {1'b1, 4'd3};
         8'h1B:   return {1'b1, 4'd4};
         8'h23:   return {1'b1, 4'd5};
         8'h1A:   return {1'b1, 4'd6};
         8'h22:   return {1'b1, 4'd7};
         8'h21:   return {1'b1, 4'd8};
         default: return 5'd0;
      endcase
   endfunction

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_scan_ready_d;
   logic             r_space_held, w_space_nxt;
   logic             r_key_valid, w_valid_nxt;
   logic             r_key_make, w_make_nxt;
   logic [3:0]       r_key_index, w_index_nxt;
   logic [8:0]       r_key_held, w_held_nxt;
   logic             r_start, w_start_nxt;
   logic             r_sync, w_sync_nxt;

   logic             w_accept;
   logic [4:0]       w_hole;
   logic             w_is_hole;
   logic [3:0]       w_hole_idx;
   logic [8:0]       w_mask;
   logic             w_is_space;
   logic             w_is_bad;
   logic             w_is_f0;
   logic             w_is_e0;

   assign w_accept   = bus.scan_ready & ~r_scan_ready_d;
   assign w_hole     = hole_map(bus.scan_code);
   assign w_is_hole  = w_hole[4];
   assign w_hole_idx = w_hole[3:0];
   assign w_mask     = 9'(1) << w_hole_idx;
   assign w_is_space = (bus.scan_code == 8'h29);
   assign w_is_bad   = (bus.scan_code == 8'h00) || (bus.scan_code == 8'hFF);
   assign w_is_f0    = (bus.scan_code == 8'hF0);
   assign w_is_e0    = (bus.scan_code == 8'hE0);

   // State, prefix timer and scan_ready edge-detect registers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_scan_ready_d <= 1'b1;   // a level already high at reset release is not an edge
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_scan_ready_d <= bus.scan_ready;
      end
   end

   // Next state, held bitmaps and next registered outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_state == IDLE) ? '0 : r_cnt + CNT_ONE;
      w_valid_nxt = 1'b0;
      w_make_nxt  = r_key_make;
      w_index_nxt = r_key_index;
      w_held_nxt  = r_key_held;
      w_space_nxt = r_space_held;
      w_start_nxt = 1'b0;
      w_sync_nxt  = 1'b0;

      if (w_accept) begin
         // An accepted byte always wins over a timeout expiring this cycle.
         w_cnt_nxt = '0;
         case (r_state)
            IDLE: begin
               if (w_is_f0) begin
                  w_state_nxt = BRK;
               end else if (w_is_e0) begin
                  w_state_nxt = EXT;
               end else if (w_is_hole) begin
                  if (!(((r_key_held & w_mask) != '0) && SUPPRESS_REPEAT)) begin
                     w_valid_nxt = 1'b1;
                     w_make_nxt  = 1'b1;
                     w_index_nxt = w_hole_idx;
                     w_held_nxt  = r_key_held | w_mask;
                  end
               end else if (w_is_space) begin
                  if (!(r_space_held && SUPPRESS_REPEAT)) begin
                     w_start_nxt = 1'b1;
                     w_space_nxt = 1'b1;
                  end
               end else if (w_is_bad) begin
                  w_sync_nxt = 1'b1;
               end
            end
            BRK: begin
               w_state_nxt = IDLE;
               if (w_is_f0) begin
                  w_state_nxt = BRK;
               end else if (w_is_e0 || w_is_bad) begin
                  w_sync_nxt = 1'b1;
               end else if (w_is_hole) begin
                  // Release of a key never seen pressed is dropped.
                  if ((r_key_held & w_mask) != '0) begin
                     w_valid_nxt = 1'b1;
                     w_make_nxt  = 1'b0;
                     w_index_nxt = w_hole_idx;
                     w_held_nxt  = r_key_held & ~w_mask;
                  end
               end else if (w_is_space) begin
                  w_space_nxt = 1'b0;
               end
            end
            EXT: begin
               // Extended codes share byte values with hole keys; never decode them.
               if (w_is_f0) begin
                  w_state_nxt = EXT_BRK;
               end else if (!w_is_e0) begin
                  w_state_nxt = IDLE;
               end
            end
            EXT_BRK: begin
               w_state_nxt = IDLE;
               if (w_is_e0 || w_is_bad) begin
                  w_sync_nxt = 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end else if ((r_state != IDLE) && (r_cnt == CNT_LAST)) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_sync_nxt  = 1'b1;
      end
   end

   // Registered event outputs and held-key bitmaps.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_key_valid  <= 1'b0;
         r_key_make   <= 1'b0;
         r_key_index  <= 4'd0;
         r_key_held   <= 9'd0;
         r_space_held <= 1'b0;
         r_start      <= 1'b0;
         r_sync       <= 1'b0;
      end else begin
         r_key_valid  <= w_valid_nxt;
         r_key_make   <= w_make_nxt;
         r_key_index  <= w_index_nxt;
         r_key_held   <= w_held_nxt;
         r_space_held <= w_space_nxt;
         r_start      <= w_start_nxt;
         r_sync       <= w_sync_nxt;
      end
   end

   assign bus.key_valid   = r_key_valid;
   assign bus.key_make    = r_key_make;
   assign bus.key_index   = r_key_index;
   assign bus.key_held    = r_key_held;
   assign bus.start_pulse = r_start;
   assign bus.sync_lost   = r_sync;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder: one instance with repeat
// suppression, one without, both with a 100-cycle prefix timeout.
module tb_ps2_key_event_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ps2_key_event_decoder_if bus ();
   ps2_key_event_decoder_if bus_nr ();

   assign bus_nr.scan_ready = bus.scan_ready;
   assign bus_nr.scan_code  = bus.scan_code;

   ps2_key_event_decoder #(.TIMEOUT_CYCLES(100), .SUPPRESS_REPEAT(1'b1)) u_dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   ps2_key_event_decoder #(.TIMEOUT_CYCLES(100), .SUPPRESS_REPEAT(1'b0)) u_dut_nr (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus_nr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int n_press    = 0;
   int n_rel      = 0;
   int n_start    = 0;
   int n_sync     = 0;
   int n_press_nr = 0;

   // Event counters sampled on the inactive edge.
   always @(negedge clk) begin
      if (bus.key_valid && bus.key_make)    n_press    <= n_press + 1;
      if (bus.key_valid && !bus.key_make)   n_rel      <= n_rel + 1;
      if (bus.start_pulse)                  n_start    <= n_start + 1;
      if (bus.sync_lost)                    n_sync     <= n_sync + 1;
      if (bus_nr.key_valid && bus_nr.key_make) n_press_nr <= n_press_nr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte on a fresh rising edge; returns on the negedge where its result is visible.
   task automatic send(input logic [7:0] code);
      @(negedge clk);
      bus.scan_ready = 1'b1;
      bus.scan_code  = code;
      @(negedge clk);
      bus.scan_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int s_press, s_rel, s_start, s_sync, s_press_nr;

   task automatic snap();
      s_press = n_press; s_rel = n_rel; s_start = n_start;
      s_sync = n_sync;   s_press_nr = n_press_nr;
   endtask

   initial begin
      bus.scan_ready = 1'b0;
      bus.scan_code  = 8'h00;
      idle(3);
      rst = 1'b0;

      // Reset state
      chk("rst_valid", 32'(bus.key_valid), 32'd0);
      chk("rst_make",  32'(bus.key_make), 32'd0);
      chk("rst_index", 32'(bus.key_index), 32'd0);
      chk("rst_held",  32'(bus.key_held), 32'd0);
      chk("rst_start", 32'(bus.start_pulse), 32'd0);
      chk("rst_sync",  32'(bus.sync_lost), 32'd0);

      // Press and release W
      send(8'h1D);
      chk("w_press_valid", 32'(bus.key_valid), 32'd1);
      chk("w_press_make",  32'(bus.key_make), 32'd1);
      chk("w_press_index", 32'(bus.key_index), 32'd1);
      chk("w_press_held",  32'(bus.key_held), 32'h002);
      idle(1);
      chk("w_pulse_1cyc",  32'(bus.key_valid), 32'd0);
      chk("w_hold_index",  32'(bus.key_index), 32'd1);
      chk("w_hold_make",   32'(bus.key_make), 32'd1);
      send(8'hF0);
      chk("w_f0_no_evt",   32'(bus.key_valid), 32'd0);
      send(8'h1D);
      chk("w_rel_valid",   32'(bus.key_valid), 32'd1);
      chk("w_rel_make",    32'(bus.key_make), 32'd0);
      chk("w_rel_index",   32'(bus.key_index), 32'd1);
      chk("w_rel_held",    32'(bus.key_held), 32'h000);

      // Typematic suppression on A
      idle(1);
      snap();
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      idle(2);
      chk("rep_press",     32'(n_press - s_press), 32'd1);
      chk("rep_rel",       32'(n_rel - s_rel), 32'd1);
      chk("rep_press_nr",  32'(n_press_nr - s_press_nr), 32'd3);
      chk("rep_index",     32'(bus.key_index), 32'd3);
      chk("rep_no_sync",   32'(n_sync - s_sync), 32'd0);

      // Extended keys ignored
      snap();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'h1D); send(8'hE0); send(8'hF0); send(8'h1D);
      idle(2);
      chk("ext_no_press",  32'(n_press - s_press), 32'd0);
      chk("ext_no_rel",    32'(n_rel - s_rel), 32'd0);
      chk("ext_no_sync",   32'(n_sync - s_sync), 32'd0);
      send(8'h15);
      chk("ext_q_valid",   32'(bus.key_valid), 32'd1);
      chk("ext_q_make",    32'(bus.key_make), 32'd1);
      chk("ext_q_index",   32'(bus.key_index), 32'd0);
      send(8'hF0); send(8'h15);
      chk("ext_q_rel",     32'(bus.key_held), 32'h000);

      // Prefix timeout
      send(8'hF0);
      idle(99);
      chk("to_not_yet",    32'(bus.sync_lost), 32'd0);
      idle(1);
      chk("to_fire",       32'(bus.sync_lost), 32'd1);
      idle(1);
      chk("to_one_cycle",  32'(bus.sync_lost), 32'd0);
      send(8'h24);
      chk("to_e_valid",    32'(bus.key_valid), 32'd1);
      chk("to_e_make",     32'(bus.key_make), 32'd1);
      chk("to_e_index",    32'(bus.key_index), 32'd2);
      send(8'hF0); send(8'h24);
      chk("to_e_rel",      32'(bus.key_held), 32'h000);

      // Space start pulses
      idle(1);
      snap();
      send(8'h29); send(8'h29); send(8'hF0); send(8'h29); send(8'h29);
      idle(2);
      chk("space_starts",  32'(n_start - s_start), 32'd2);
      chk("space_no_key",  32'(n_press - s_press), 32'd0);

      // Illegal prefix order and bad bytes
      send(8'hF0); send(8'hE0);
      chk("f0e0_sync",     32'(bus.sync_lost), 32'd1);
      send(8'h00);
      chk("idle00_sync",   32'(bus.sync_lost), 32'd1);
      send(8'hAA);
      chk("aa_no_sync",    32'(bus.sync_lost), 32'd0);
      chk("aa_no_valid",   32'(bus.key_valid), 32'd0);

      // scan_ready held high for 5 cycles: one accept
      idle(1);
      snap();
      @(negedge clk);
      bus.scan_ready = 1'b1;
      bus.scan_code  = 8'h1D;
      idle(5);
      bus.scan_ready = 1'b0;
      idle(2);
      chk("long_rdy_press", 32'(n_press - s_press), 32'd1);
      chk("long_rdy_held",  32'(bus.key_held), 32'h002);
      send(8'hF0); send(8'h1D);
      chk("long_rdy_rel",   32'(bus.key_make), 32'd0);

      // Reset with Q and C held and F0 pending
      send(8'h15); send(8'h21);
      chk("pre_rst_held",  32'(bus.key_held), 32'h101);
      send(8'hF0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(bus.key_valid), 32'd0);
      chk("mid_rst_make",  32'(bus.key_make), 32'd0);
      chk("mid_rst_index", 32'(bus.key_index), 32'd0);
      chk("mid_rst_held",  32'(bus.key_held), 32'h000);
      bus.scan_ready = 1'b1;
      bus.scan_code  = 8'h1D;
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      snap();
      idle(3);
      chk("rdy_hi_no_acc",  32'(n_press - s_press), 32'd0);
      chk("rdy_hi_held",    32'(bus.key_held), 32'h000);
      bus.scan_ready = 1'b0;
      idle(1);
      send(8'h1D);
      chk("post_rst_valid", 32'(bus.key_valid), 32'd1);
      chk("post_rst_make",  32'(bus.key_make), 32'd1);
      chk("post_rst_index", 32'(bus.key_index), 32'd1);
      chk("post_rst_held",  32'(bus.key_held), 32'h002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
